// File: rtl/fifo_read_ctrl.sv
// Read-side master for async_fifo: converts the 1-cycle-latency r_en/r_data port
// into a valid/ready stream through a 2-entry skid buffer, with flush and a word counter.
module fifo_read_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             r_clk,
    input  logic             rst_r_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_r_data,
    output logic             fifo_r_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count,
    output logic             dbg_state
);

    // Stream handshake: a word transfers on every r_clk edge where m_valid && m_ready;
    // m_data holds steady while m_valid is high and m_ready is low.
    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q, inflight_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pop;
    logic [2:0]         fill;

    always_comb begin
        state_d   = state_q;
        occ_d     = occ_q;
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;
        fifo_r_en = 1'b0;

        m_valid = (occ_q != 2'd0);
        pop     = m_valid && m_ready;
        // Slots committed after this edge; a read is only issued if it is guaranteed room.
        fill    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

        if (pop) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_RUN: begin
                fifo_r_en = !fifo_empty && (fill < 3'd2);
                if (flush) begin
                    state_d = S_FLUSH;
                    occ_d   = 2'd0;
                    head_d  = '0;
                    tail_d  = '0;
                end else begin
                    case ({inflight_q, pop})
                        2'b01: begin
                            head_d = tail_q;
                            occ_d  = occ_q - 2'd1;
                        end
                        2'b10: begin
                            if (occ_q == 2'd0) begin
                                head_d = fifo_r_data;
                            end else begin
                                tail_d = fifo_r_data;
                            end
                            occ_d = occ_q + 2'd1;
                        end
                        2'b11: begin
                            if (occ_q == 2'd1) begin
                                head_d = fifo_r_data;
                            end else begin
                                head_d = tail_q;
                                tail_d = fifo_r_data;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_FLUSH: begin
                // Drain the FIFO; returning read data is simply not captured.
                fifo_r_en = !fifo_empty;
                if (!flush && fifo_empty && !inflight_q) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        inflight_d = fifo_r_en;
    end

    always_ff @(posedge r_clk or negedge rst_r_n) begin
        if (!rst_r_n) begin
            state_q    <= S_RUN;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    assign m_data    = head_q;
    assign rd_count  = cnt_q;
    assign busy      = (state_q == S_FLUSH) || (occ_q != 2'd0) || inflight_q;
    assign dbg_state = (state_q == S_FLUSH);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: a queue-based FIFO model with 1-cycle read latency feeds the
// DUT; written words go to a scoreboard queue and are compared on each accepted transfer.
module tb_fifo_read_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             r_clk;
    logic             rst_r_n;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_r_data;
    logic             fifo_r_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] rd_count;
    logic             dbg_state;

    logic [WIDTH-1:0] mem_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               chk_total = 0;
    int               chk_pass  = 0;
    int               ren_cnt   = 0;

    fifo_read_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .r_clk       (r_clk),
        .rst_r_n     (rst_r_n),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_r_en   (fifo_r_en),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .flush       (flush),
        .busy        (busy),
        .rd_count    (rd_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", chk_pass, chk_total);
        $fatal(1, "timeout");
    end

    // ---------------- FIFO model ----------------
    initial begin
        fifo_empty  = 1'b1;
        fifo_r_data = '0;
    end

    always @(posedge r_clk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_r_data <= mem_q.pop_front();
        end
        fifo_empty <= (mem_q.size() == 0);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_total++;
        assert (obs === exp) chk_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    always @(negedge r_clk) begin
        if (rst_r_n) begin
            if (fifo_r_en) ren_cnt++;
            check("ren_while_empty", {31'b0, fifo_r_en && fifo_empty}, 32'd0);
            if (m_valid && m_ready) begin
                check("scoreboard_has_word", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("m_data_order", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        mem_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge r_clk);
            #1;
            k++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int k;
        rst_r_n = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        #12;
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_m_data", {24'b0, m_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ren", {31'b0, fifo_r_en}, 32'd0);
        check("rst_rd_count", {16'b0, rd_count}, 32'd0);
        check("rst_state", {31'b0, dbg_state}, 32'd0);
        step(1);
        rst_r_n = 1'b1;

        // 1: empty FIFO, ready high, nothing happens
        m_ready = 1'b1;
        ren_cnt = 0;
        step(20);
        check("t1_ren_count", ren_cnt, 32'd0);
        check("t1_m_valid", {31'b0, m_valid}, 32'd0);
        check("t1_busy", {31'b0, busy}, 32'd0);
        check("t1_rd_count", {16'b0, rd_count}, 32'd0);

        // 2: stream 0..15 back to back
        for (int i = 0; i < 16; i++) wr(WIDTH'(i));
        k = 0;
        do begin
            @(negedge r_clk);
            #1;
            k++;
        end while (!m_valid && k < 50);
        check("t2_first_valid", {31'b0, m_valid}, 32'd1);
        cyc = 1;
        while (exp_q.size() != 0 && cyc < 64) begin
            @(negedge r_clk);
            #1;
            cyc++;
        end
        check("t2_stream_cycles", cyc, 32'd16);
        step(2);
        check("t2_rd_count", {16'b0, rd_count}, 32'd16);

        // 3: back-pressure, only two reads issued, head held
        m_ready = 1'b0;
        ren_cnt = 0;
        for (int i = 0; i < 4; i++) wr(WIDTH'(8'h10 + i));
        step(3);
        check("t3_hold_data_early", {24'b0, m_data}, 32'h10);
        step(7);
        check("t3_ren_pulses", ren_cnt, 32'd2);
        check("t3_m_valid", {31'b0, m_valid}, 32'd1);
        check("t3_hold_data", {24'b0, m_data}, 32'h10);
        m_ready = 1'b1;
        wait_drain("t3_drain", 50);
        step(2);
        check("t3_rd_count", {16'b0, rd_count}, 32'd20);

        // 4: toggling ready with 32 random words
        for (int i = 0; i < 32; i++) wr(WIDTH'($urandom_range(0, 255)));
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            step(1);
            m_ready = ~m_ready;
        end
        check("t4_all_received", exp_q.size(), 32'd0);
        m_ready = 1'b0;
        step(2);
        check("t4_rd_count", {16'b0, rd_count}, 32'd52);

        // 5: load 8, accept 2, flush, then a fresh word
        for (int i = 0; i < 8; i++) wr(WIDTH'(8'h40 + i));
        step(5);
        m_ready = 1'b1;
        step(2);
        m_ready = 1'b0;
        step(2);
        check("t5_pre_flush_valid", {31'b0, m_valid}, 32'd1);
        flush = 1'b1;
        exp_q.delete();
        step(1);
        flush = 1'b0;
        check("t5_flush_valid", {31'b0, m_valid}, 32'd0);
        check("t5_flush_state", {31'b0, dbg_state}, 32'd1);
        k = 0;
        while (busy && k < 50) begin
            step(1);
            k++;
        end
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_fifo_drained", {31'b0, fifo_empty}, 32'd1);
        check("t5_state_run", {31'b0, dbg_state}, 32'd0);
        check("t5_rd_count", {16'b0, rd_count}, 32'd54);
        wr(8'hAA);
        m_ready = 1'b1;
        wait_drain("t5_after_flush_word", 20);
        step(1);
        check("t5_rd_count_after", {16'b0, rd_count}, 32'd55);

        // 6: async reset while the skid buffer is full
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(WIDTH'(8'h60 + i));
        step(6);
        check("t6_pre_valid", {31'b0, m_valid}, 32'd1);
        check("t6_pre_busy", {31'b0, busy}, 32'd1);
        #2;
        rst_r_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_valid", {31'b0, m_valid}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_rd_count", {16'b0, rd_count}, 32'd0);
        check("t6_rst_data", {24'b0, m_data}, 32'd0);
        step(2);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
